// File: rtl/sum_avg_pkg.sv
// Shared types and sizing helpers for the sum-window averager and its min/max tracker.
package sum_avg_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LOG2_N_DEF = 2;

    function automatic int acc_w(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

    localparam int ACC_W_DEF = acc_w(DATA_W_DEF, LOG2_N_DEF);

    // Default-width view of one window result; the top re-declares it at its own widths.
    typedef struct packed {
        logic [ACC_W_DEF-1:0]  sum;
        logic [DATA_W_DEF-1:0] avg;
        logic [DATA_W_DEF-1:0] min_v;
        logic [DATA_W_DEF-1:0] max_v;
    } win_result_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_STALL = 2'd3
    } win_state_e;

endpackage

// File: rtl/window_minmax.sv
// Running minimum/maximum of the samples in the current window, plus the
// values that would result if the presented sample were folded in.
module window_minmax
    import sum_avg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_update,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_min,
    output logic [DATA_W-1:0] o_max,
    output logic [DATA_W-1:0] o_min_next,
    output logic [DATA_W-1:0] o_max_next
);

    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] w_min_next;
    logic [DATA_W-1:0] w_max_next;

    // Candidate extremes including the presented sample.
    always_comb begin
        w_min_next = r_min;
        w_max_next = r_max;
        if (i_data < r_min) begin
            w_min_next = i_data;
        end else begin
            w_min_next = r_min;
        end
        if (i_data > r_max) begin
            w_max_next = i_data;
        end else begin
            w_max_next = r_max;
        end
    end

    // Running extremes: empty window is min=all-ones, max=zero.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_min <= '1;
            r_max <= '0;
        end else if (i_load) begin
            r_min <= i_data;
            r_max <= i_data;
        end else if (i_update) begin
            r_min <= w_min_next;
            r_max <= w_max_next;
        end
    end

    assign o_min      = r_min;
    assign o_max      = r_max;
    assign o_min_next = w_min_next;
    assign o_max_next = w_max_next;

endmodule

// File: rtl/sum_window_averager.sv
// Collects windows of 2**LOG2_N samples and emits sum, truncated mean, min
// and max through a one-entry registered output with valid/ready.
module sum_window_averager
    import sum_avg_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int LOG2_N = LOG2_N_DEF,
    localparam int ACC_W  = acc_w(DATA_W, LOG2_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_avg,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [7:0]        win_count
);

    typedef struct packed {
        logic [ACC_W-1:0]  sum;
        logic [DATA_W-1:0] avg;
        logic [DATA_W-1:0] min_v;
        logic [DATA_W-1:0] max_v;
    } res_t;

    localparam logic [LOG2_N-1:0] CNT_ZERO = '0;
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;
    localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);

    logic [LOG2_N-1:0] r_cnt;
    logic [ACC_W-1:0]  r_acc;
    res_t              r_res;
    logic              r_out_valid;
    logic [7:0]        r_win_count;

    logic              w_last;
    logic              w_fire;
    logic              w_take;
    logic              w_close;
    logic              w_accum;
    logic [ACC_W-1:0]  w_sum;
    logic [DATA_W-1:0] w_min_run;
    logic [DATA_W-1:0] w_max_run;
    logic [DATA_W-1:0] w_min_next;
    logic [DATA_W-1:0] w_max_next;
    win_state_e        w_state;

    assign w_last = (r_cnt == CNT_LAST);

    // Window state is a pure decode of {out_valid, cnt}; only STALL blocks input.
    always_comb begin
        w_state = ST_EMPTY;
        if (r_out_valid) begin
            if (w_last) begin
                w_state = ST_STALL;
            end else begin
                w_state = ST_HOLD;
            end
        end else begin
            if (r_cnt == CNT_ZERO) begin
                w_state = ST_EMPTY;
            end else begin
                w_state = ST_FILL;
            end
        end
    end

    assign in_ready = (w_state != ST_STALL);
    assign w_fire   = in_valid & in_ready;
    // clr outranks the sample even though in_ready is still reported.
    assign w_take   = w_fire & ~clr;
    assign w_close  = w_take & w_last;
    assign w_accum  = w_take & ~w_last;
    assign w_sum    = r_acc + ACC_W'(in_data);

    window_minmax #(
        .DATA_W (DATA_W)
    ) u_minmax (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (clr | w_close),
        .i_load     (w_accum & (r_cnt == CNT_ZERO)),
        .i_update   (w_accum),
        .i_data     (in_data),
        .o_min      (w_min_run),
        .o_max      (w_max_run),
        .o_min_next (w_min_next),
        .o_max_next (w_max_next)
    );

    // Sample counter and accumulator for the window being filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= CNT_ZERO;
            r_acc <= '0;
        end else if (clr || w_close) begin
            r_cnt <= CNT_ZERO;
            r_acc <= '0;
        end else if (w_accum) begin
            r_cnt <= r_cnt + CNT_ONE;
            r_acc <= w_sum;
        end
    end

    // One-entry result register; a closing window takes precedence over a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res       <= '0;
            r_out_valid <= 1'b0;
            r_win_count <= 8'd0;
        end else if (w_close) begin
            r_res.sum   <= w_sum;
            r_res.avg   <= w_sum[ACC_W-1:LOG2_N];
            r_res.min_v <= w_min_next;
            r_res.max_v <= w_max_next;
            r_out_valid <= 1'b1;
            r_win_count <= r_win_count + 8'd1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_res.sum;
    assign out_avg   = r_res.avg;
    assign out_min   = r_res.min_v;
    assign out_max   = r_res.max_v;
    assign win_count = r_win_count;

endmodule

// File: tb/tb_sum_window_averager.sv
// Scoreboard bench for sum_window_averager: a window-level reference model
// predicts each result, a monitor compares on every output transfer.
module tb_sum_window_averager;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int AW = 10;

    typedef struct {
        int unsigned sum;
        int unsigned avg;
        int unsigned mn;
        int unsigned mx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [DW-1:0] out_avg;
    logic [DW-1:0] out_min;
    logic [DW-1:0] out_max;
    logic [7:0]    win_count;

    int n_cmp = 0;
    int n_bad = 0;
    int stalls = 0;
    bit mon_en = 1'b0;
    bit rand_rdy = 1'b0;

    logic [DW-1:0] win[$];
    exp_t          exp_q[$];
    int unsigned   mdl_wc = 0;

    bit            hold_prev = 1'b0;
    logic [AW-1:0] hold_sum;
    logic [DW-1:0] hold_avg, hold_min, hold_max;

    sum_window_averager dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_avg   (out_avg),
        .out_min   (out_min),
        .out_max   (out_max),
        .win_count (win_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference: a window is just the list of accepted samples; results are plain arithmetic.
    task automatic mon_step();
        exp_t e;
        int unsigned s, mn, mx;
        if (hold_prev) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(out_sum), 32'(hold_sum));
            check("hold_avg", 32'(out_avg), 32'(hold_avg));
            check("hold_min", 32'(out_min), 32'(hold_min));
            check("hold_max", 32'(out_max), 32'(hold_max));
        end
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(!(exp_q.size() > 0 && win.size() == N - 1)));
        check("win_count", 32'(win_count), mdl_wc);
        hold_prev = !rst && out_valid && !out_ready;
        hold_sum  = out_sum;
        hold_avg  = out_avg;
        hold_min  = out_min;
        hold_max  = out_max;
        if (rst) begin
            win.delete();
            exp_q.delete();
            mdl_wc    = 0;
            hold_prev = 1'b0;
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("res_sum", 32'(out_sum), e.sum);
                check("res_avg", 32'(out_avg), e.avg);
                check("res_min", 32'(out_min), e.mn);
                check("res_max", 32'(out_max), e.mx);
            end
            if (clr) begin
                win.delete();
            end else if (in_valid && in_ready) begin
                win.push_back(in_data);
                if (win.size() == N) begin
                    s = 0; mn = 255; mx = 0;
                    foreach (win[k]) begin
                        s += win[k];
                        if (win[k] < mn) mn = win[k];
                        if (win[k] > mx) mx = win[k];
                    end
                    e.sum = s; e.avg = s / N; e.mn = mn; e.mx = mx;
                    exp_q.push_back(e);
                    win.delete();
                    mdl_wc = (mdl_wc + 1) % 256;
                end
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (mon_en) mon_step();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [DW-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        stalls += n;
        check("send_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_res(input string nm, input int s, input int a, input int mn, input int mx, input int wc);
        check({nm, "_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_sum"}, 32'(out_sum), s);
        check({nm, "_avg"}, 32'(out_avg), a);
        check({nm, "_min"}, 32'(out_min), mn);
        check({nm, "_max"}, 32'(out_max), mx);
        check({nm, "_wc"}, 32'(win_count), wc);
    endtask

    initial begin
        int n;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        fork
            monitor();
        join_none
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(out_sum), 32'd0);
        check("rst_avg", 32'(out_avg), 32'd0);
        check("rst_min", 32'(out_min), 32'd0);
        check("rst_max", 32'(out_max), 32'd0);
        check("rst_wc", 32'(win_count), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        send(8'd10); send(8'd20); send(8'd30); send(8'd40);
        check_res("basic", 100, 25, 10, 40, 1);
        tick();

        repeat (4) send(8'd255);
        check_res("full", 1020, 255, 255, 255, 2);
        send(8'd0); send(8'd0); send(8'd0); send(8'd3);
        check_res("low", 3, 0, 0, 3, 3);
        tick();

        out_ready = 1'b0;
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        send(8'd5); send(8'd6); send(8'd7);
        in_valid = 1'b1;
        in_data  = 8'd8;
        repeat (3) begin
            tick();
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_sum", 32'(out_sum), 32'd10);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_res("bp", 26, 6, 5, 8, 5);
        out_ready = 1'b1;
        tick();

        send(8'd50); send(8'd60);
        clr = 1'b1; in_valid = 1'b1; in_data = 8'd70;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        check_res("clr", 4, 1, 1, 1, 6);
        tick();

        out_ready = 1'b0;
        repeat (4) send(8'd9);
        send(8'd7); send(8'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_wc", 32'(win_count), 32'd0);
        out_ready = 1'b1;
        send(8'd100); send(8'd101); send(8'd102); send(8'd103);
        check_res("mrst", 406, 101, 100, 103, 1);

        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            n = int'($urandom_range(0, 19));
            if (n == 0) begin
                clr = 1'b1; in_valid = 1'b1; in_data = 8'($urandom_range(0, 255));
                tick();
                clr = 1'b0; in_valid = 1'b0;
            end else if (n == 1) begin
                tick();
            end else begin
                send(8'($urandom_range(0, 255)));
            end
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        stalls = 0;
        for (int w = 0; w < 256; w++) begin
            for (int j = 0; j < N; j++) send(8'($urandom_range(0, 255)));
            if (w == 254) check("wrap_255", 32'(win_count), 32'd255);
        end
        check("wrap_zero", 32'(win_count), 32'd0);
        check("wrap_stalls", 32'(stalls), 32'd0);

        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
